// File: rtl/reindeer_mem_arbiter_if.sv
// Request/completion bus between the core's fetch and load/store units,
// the memory arbiter, and the memory controller port.
interface reindeer_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      fetch_read_enable;
    logic [ADDR_WIDTH-1:0]     fetch_read_addr;
    logic                      fetch_done;
    logic [DATA_WIDTH-1:0]     fetch_data;
    logic                      data_enable;
    logic                      data_we;
    logic [ADDR_WIDTH-1:0]     data_addr;
    logic [DATA_WIDTH-1:0]     data_wdata;
    logic [DATA_WIDTH/8-1:0]   data_byte_en;
    logic                      data_done;
    logic [DATA_WIDTH-1:0]     data_rdata;
    logic                      access_error;
    logic                      mem_enable;
    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_byte_en;
    logic                      mem_done;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    // Arbiter side
    modport slave (
        input  fetch_read_enable, fetch_read_addr,
        input  data_enable, data_we, data_addr, data_wdata, data_byte_en,
        input  mem_done, mem_rdata,
        output fetch_done, fetch_data, data_done, data_rdata, access_error,
        output mem_enable, mem_we, mem_addr, mem_wdata, mem_byte_en
    );

    // Requesters plus memory controller side
    modport master (
        output fetch_read_enable, fetch_read_addr,
        output data_enable, data_we, data_addr, data_wdata, data_byte_en,
        output mem_done, mem_rdata,
        input  fetch_done, fetch_data, data_done, data_rdata, access_error,
        input  mem_enable, mem_we, mem_addr, mem_wdata, mem_byte_en
    );
endinterface

// File: rtl/reindeer_mem_arbiter.sv
// Shares one memory-controller port between instruction fetch and load/store,
// data-over-fetch priority, with a grant-to-done watchdog.
module reindeer_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sync_reset,
    reindeer_mem_arbiter_if.slave bus
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE       = 3'b001,
        S_FETCH_BUSY = 3'b010,
        S_DATA_BUSY  = 3'b100
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  fv_q, fv_d, dv_q, dv_d, dwe_q, dwe_d;
    logic [ADDR_WIDTH-1:0] faddr_q, faddr_d, daddr_q, daddr_d;
    logic [DATA_WIDTH-1:0] dwdata_q, dwdata_d;
    logic [BE_W-1:0]       dbe_q, dbe_d;

    logic                  fetch_done_q, fetch_done_d, data_done_q, data_done_d;
    logic                  access_error_q, access_error_d;
    logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d, data_rdata_q, data_rdata_d;
    logic                  mem_enable_q, mem_enable_d, mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]       mem_byte_en_q, mem_byte_en_d;

    // A same-cycle pulse counts as pending so an idle arbiter grants it at once
    logic                  f_pend, d_pend, d_we;
    logic [ADDR_WIDTH-1:0] f_addr, d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [BE_W-1:0]       d_be;

    assign f_pend  = fv_q | bus.fetch_read_enable;
    assign f_addr  = bus.fetch_read_enable ? bus.fetch_read_addr : faddr_q;
    assign d_pend  = dv_q | bus.data_enable;
    assign d_we    = bus.data_enable ? bus.data_we      : dwe_q;
    assign d_addr  = bus.data_enable ? bus.data_addr    : daddr_q;
    assign d_wdata = bus.data_enable ? bus.data_wdata   : dwdata_q;
    assign d_be    = bus.data_enable ? bus.data_byte_en : dbe_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        fv_d           = fv_q;
        faddr_d        = faddr_q;
        dv_d           = dv_q;
        dwe_d          = dwe_q;
        daddr_d        = daddr_q;
        dwdata_d       = dwdata_q;
        dbe_d          = dbe_q;
        fetch_done_d   = 1'b0;
        data_done_d    = 1'b0;
        access_error_d = 1'b0;
        fetch_data_d   = fetch_data_q;
        data_rdata_d   = data_rdata_q;
        mem_enable_d   = 1'b0;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_byte_en_d  = mem_byte_en_q;

        if (bus.fetch_read_enable) begin
            fv_d    = 1'b1;
            faddr_d = bus.fetch_read_addr;
        end
        if (bus.data_enable) begin
            dv_d     = 1'b1;
            dwe_d    = bus.data_we;
            daddr_d  = bus.data_addr;
            dwdata_d = bus.data_wdata;
            dbe_d    = bus.data_byte_en;
        end

        if (sync_reset) begin
            state_d = S_IDLE;
            fv_d    = 1'b0;
            dv_d    = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (d_pend) begin
                        dv_d          = 1'b0;
                        mem_enable_d  = 1'b1;
                        mem_we_d      = d_we;
                        mem_addr_d    = d_addr;
                        mem_wdata_d   = d_wdata;
                        mem_byte_en_d = d_we ? d_be : '1;
                        cnt_d         = '0;
                        state_d       = S_DATA_BUSY;
                    end else if (f_pend) begin
                        fv_d          = 1'b0;
                        mem_enable_d  = 1'b1;
                        mem_we_d      = 1'b0;
                        mem_addr_d    = f_addr;
                        mem_wdata_d   = '0;
                        mem_byte_en_d = '1;
                        cnt_d         = '0;
                        state_d       = S_FETCH_BUSY;
                    end
                end
                S_FETCH_BUSY: begin
                    if (bus.mem_done) begin
                        fetch_done_d = 1'b1;
                        fetch_data_d = bus.mem_rdata;
                        state_d      = S_IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        fetch_done_d   = 1'b1;
                        fetch_data_d   = '0;
                        access_error_d = 1'b1;
                        state_d        = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DATA_BUSY: begin
                    // mem_we_q still reflects the in-flight access: stores return 0
                    if (bus.mem_done) begin
                        data_done_d  = 1'b1;
                        data_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
                        state_d      = S_IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        data_done_d    = 1'b1;
                        data_rdata_d   = '0;
                        access_error_d = 1'b1;
                        state_d        = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            fv_q           <= 1'b0;
            faddr_q        <= '0;
            dv_q           <= 1'b0;
            dwe_q          <= 1'b0;
            daddr_q        <= '0;
            dwdata_q       <= '0;
            dbe_q          <= '0;
            fetch_done_q   <= 1'b0;
            data_done_q    <= 1'b0;
            access_error_q <= 1'b0;
            fetch_data_q   <= '0;
            data_rdata_q   <= '0;
            mem_enable_q   <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_byte_en_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fv_q           <= fv_d;
            faddr_q        <= faddr_d;
            dv_q           <= dv_d;
            dwe_q          <= dwe_d;
            daddr_q        <= daddr_d;
            dwdata_q       <= dwdata_d;
            dbe_q          <= dbe_d;
            fetch_done_q   <= fetch_done_d;
            data_done_q    <= data_done_d;
            access_error_q <= access_error_d;
            fetch_data_q   <= fetch_data_d;
            data_rdata_q   <= data_rdata_d;
            mem_enable_q   <= mem_enable_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_byte_en_q  <= mem_byte_en_d;
        end
    end

    assign bus.fetch_done   = fetch_done_q;
    assign bus.fetch_data   = fetch_data_q;
    assign bus.data_done    = data_done_q;
    assign bus.data_rdata   = data_rdata_q;
    assign bus.access_error = access_error_q;
    assign bus.mem_enable   = mem_enable_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_byte_en  = mem_byte_en_q;
endmodule

// File: tb/tb_reindeer_mem_arbiter.sv
// Bench for reindeer_mem_arbiter: vector table plus hand-built corner sequences,
// issued accesses and completions are checked against scoreboard queues.
module tb_reindeer_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int T  = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic sync_reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reindeer_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    reindeer_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .bus(bus.slave)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } iss_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } cpl_t;

    typedef struct {
        bit            is_data;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        logic [DW-1:0] mrdata;
        int            lat;
        bit            no_done;
        logic [BW-1:0] exp_be;
        logic [DW-1:0] exp_data;
        bit            exp_err;
        int            exp_dly;
    } vec_t;

    iss_t iq[$];
    cpl_t fq[$];
    cpl_t dq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every DUT strobe is matched against the oldest expectation
    iss_t ie;
    cpl_t ce;
    logic pe = 1'b0, pf = 1'b0, pd = 1'b0, pa = 1'b0;
    always @(negedge clk) begin
        if (bus.mem_enable) begin
            if (iq.size() == 0) check("mem_enable unexpected", bus.mem_enable, 1'b0);
            else begin
                ie = iq.pop_front();
                check("mem_we", bus.mem_we, ie.we);
                check("mem_addr", bus.mem_addr, ie.addr);
                check("mem_byte_en", bus.mem_byte_en, ie.be);
                if (ie.we) check("mem_wdata", bus.mem_wdata, ie.wdata);
            end
        end
        if (bus.fetch_done) begin
            if (fq.size() == 0) check("fetch_done unexpected", bus.fetch_done, 1'b0);
            else begin
                ce = fq.pop_front();
                check("fetch_data", bus.fetch_data, ce.data);
                check("fetch access_error", bus.access_error, ce.err);
            end
        end
        if (bus.data_done) begin
            if (dq.size() == 0) check("data_done unexpected", bus.data_done, 1'b0);
            else begin
                ce = dq.pop_front();
                check("data_rdata", bus.data_rdata, ce.data);
                check("data access_error", bus.access_error, ce.err);
            end
        end
        if (bus.access_error && !bus.fetch_done && !bus.data_done)
            check("access_error without done", bus.access_error, 1'b0);
        if (bus.mem_enable || bus.fetch_done || bus.data_done || bus.access_error)
            check("back-to-back pulse", {bus.mem_enable & pe, bus.fetch_done & pf,
                  bus.data_done & pd, bus.access_error & pa}, 4'b0);
        pe <= bus.mem_enable;
        pf <= bus.fetch_done;
        pd <= bus.data_done;
        pa <= bus.access_error;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mem_enable) begin
                c = cyc;
                return;
            end
        end
        check("mem_enable wait", bus.mem_enable, 1'b1);
    endtask

    task automatic wait_done(input bit is_data, output int c);
        c = -1;
        for (int i = 0; i < T + 30; i++) begin
            @(negedge clk);
            if (is_data ? bus.data_done : bus.fetch_done) begin
                c = cyc;
                return;
            end
        end
        check("done wait", is_data ? bus.data_done : bus.fetch_done, 1'b1);
    endtask

    // Called at a negedge: answer lat cycles after the next posedge
    task automatic mem_reply(input int lat, input logic [DW-1:0] rd);
        step();
        repeat (lat) step();
        bus.mem_done = 1'b1;
        bus.mem_rdata = rd;
        step();
        bus.mem_done = 1'b0;
    endtask

    task automatic drive_req(input vec_t v);
        if (v.is_data) begin
            bus.data_enable  = 1'b1;
            bus.data_we      = v.we;
            bus.data_addr    = v.addr;
            bus.data_wdata   = v.wdata;
            bus.data_byte_en = v.be;
        end else begin
            bus.fetch_read_enable = 1'b1;
            bus.fetch_read_addr   = v.addr;
        end
    endtask

    task automatic release_req();
        bus.data_enable = 1'b0;
        bus.fetch_read_enable = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int p, g, d;
        iq.push_back('{v.we, v.addr, v.wdata, v.exp_be});
        if (v.is_data) dq.push_back('{v.exp_data, v.exp_err});
        else fq.push_back('{v.exp_data, v.exp_err});
        drive_req(v);
        p = cyc;
        step();
        release_req();
        wait_en(g);
        check("grant latency", g, p + 1);
        if (!v.no_done) mem_reply(v.lat, v.mrdata);
        wait_done(v.is_data, d);
        check("done latency", d, g + v.exp_dly);
        if (v.no_done) begin
            // Orphan completion for the timed-out access must vanish
            repeat (5) step();
            bus.mem_done = 1'b1;
            bus.mem_rdata = 32'hFFFF_0000;
            step();
            bus.mem_done = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("orphan mem_done ignored", {bus.fetch_done, bus.data_done, bus.mem_enable}, 3'b0);
            end
        end
        step();
    endtask

    vec_t vt[7];
    int g1, g2, d1, d2;

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        //        data we addr          wdata          be     mrdata         lat no  exp_be exp_data       err dly
        vt[0] = '{0, 0, 32'h0000_0100, 32'h0,         4'hF, 32'hDEAD_BEEF, 2, 0, 4'hF, 32'hDEAD_BEEF, 0, 4};
        vt[1] = '{1, 0, 32'h0000_2000, 32'h0000_AAAA, 4'h3, 32'h1122_3344, 0, 0, 4'hF, 32'h1122_3344, 0, 2};
        vt[2] = '{1, 1, 32'h0000_3000, 32'hCAFE_F00D, 4'hC, 32'h0000_0099, 1, 0, 4'hC, 32'h0,         0, 3};
        vt[3] = '{0, 0, 32'h0000_0104, 32'h0,         4'hF, 32'h1357_9BDF, 7, 0, 4'hF, 32'h1357_9BDF, 0, 9};
        vt[4] = '{0, 0, 32'h0000_0108, 32'h0,         4'hF, 32'h0,         0, 1, 4'hF, 32'h0,         1, 9};
        vt[5] = '{1, 1, 32'h0000_4000, 32'h7777_7777, 4'hF, 32'h0,         0, 1, 4'hF, 32'h0,         1, 9};
        vt[6] = '{1, 0, 32'h0000_5000, 32'h0,         4'h1, 32'h0BAD_CAFE, 6, 0, 4'hF, 32'h0BAD_CAFE, 0, 8};

        reset_n = 1'b0;
        sync_reset = 1'b0;
        bus.fetch_read_enable = 1'b0;
        bus.fetch_read_addr = '0;
        bus.data_enable = 1'b0;
        bus.data_we = 1'b0;
        bus.data_addr = '0;
        bus.data_wdata = '0;
        bus.data_byte_en = '0;
        bus.mem_done = 1'b0;
        bus.mem_rdata = '0;
        repeat (3) step();
        check("reset pulses", {bus.mem_enable, bus.fetch_done, bus.data_done, bus.access_error, bus.mem_we}, 5'b0);
        check("reset mem_addr", bus.mem_addr, 0);
        check("reset mem_byte_en", bus.mem_byte_en, 0);
        check("reset data words", {bus.fetch_data, bus.data_rdata, bus.mem_wdata}, 0);
        reset_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Collision: store wins, fetch follows one cycle after data_done
        iq.push_back('{1'b1, 32'h0000_8000, 32'h0000_0055, 4'h1});
        iq.push_back('{1'b0, 32'h0000_0200, 32'h0, 4'hF});
        dq.push_back('{32'h0, 1'b0});
        fq.push_back('{32'hFEED_FACE, 1'b0});
        bus.fetch_read_enable = 1'b1;
        bus.fetch_read_addr = 32'h0000_0200;
        bus.data_enable = 1'b1;
        bus.data_we = 1'b1;
        bus.data_addr = 32'h0000_8000;
        bus.data_wdata = 32'h0000_0055;
        bus.data_byte_en = 4'h1;
        step();
        release_req();
        wait_en(g1);
        mem_reply(1, 32'h1234_5678);
        wait_done(1'b1, d1);
        wait_en(g2);
        check("fetch grant after data_done", g2, d1 + 1);
        mem_reply(0, 32'hFEED_FACE);
        wait_done(1'b0, d2);
        check("collision fetch done latency", d2, g2 + 2);
        step();

        // Overwrite: only the latest fetch pulse issues
        iq.push_back('{1'b0, 32'h0000_9000, 32'h0, 4'hF});
        iq.push_back('{1'b0, 32'h0000_0304, 32'h0, 4'hF});
        dq.push_back('{32'h600D_D00D, 1'b0});
        fq.push_back('{32'h0304_C0DE, 1'b0});
        bus.data_enable = 1'b1;
        bus.data_we = 1'b0;
        bus.data_addr = 32'h0000_9000;
        step();
        release_req();
        wait_en(g1);
        step();
        bus.fetch_read_enable = 1'b1;
        bus.fetch_read_addr = 32'h0000_0300;
        step();
        bus.fetch_read_addr = 32'h0000_0304;
        step();
        release_req();
        bus.mem_done = 1'b1;
        bus.mem_rdata = 32'h600D_D00D;
        step();
        bus.mem_done = 1'b0;
        wait_done(1'b1, d1);
        wait_en(g2);
        check("overwritten fetch grant", g2, d1 + 1);
        mem_reply(1, 32'h0304_C0DE);
        wait_done(1'b0, d2);
        repeat (4) step();

        // sync_reset while fetch busy and data pending; same-cycle pulse dropped
        iq.push_back('{1'b0, 32'h0000_0400, 32'h0, 4'hF});
        bus.fetch_read_enable = 1'b1;
        bus.fetch_read_addr = 32'h0000_0400;
        step();
        release_req();
        wait_en(g1);
        step();
        bus.data_enable = 1'b1;
        bus.data_we = 1'b1;
        bus.data_addr = 32'h0000_A000;
        step();
        bus.data_enable = 1'b0;
        sync_reset = 1'b1;
        bus.fetch_read_enable = 1'b1;
        bus.fetch_read_addr = 32'h0000_0500;
        step();
        sync_reset = 1'b0;
        release_req();
        for (int i = 0; i < 6; i++) begin
            bus.mem_done = (i == 2);
            @(negedge clk);
            check("flushed: no enable/done", {bus.mem_enable, bus.fetch_done, bus.data_done, bus.access_error}, 4'b0);
            step();
        end
        bus.mem_done = 1'b0;
        run_vec(vt[0]);

        // Async reset mid-access clears outputs immediately
        iq.push_back('{1'b0, 32'h0000_0700, 32'h0, 4'hF});
        bus.fetch_read_enable = 1'b1;
        bus.fetch_read_addr = 32'h0000_0700;
        step();
        release_req();
        wait_en(g1);
        #2 reset_n = 1'b0;
        #1;
        check("async reset pulses", {bus.mem_enable, bus.fetch_done, bus.data_done, bus.access_error, bus.mem_we}, 5'b0);
        check("async reset mem_addr", bus.mem_addr, 0);
        check("async reset mem_byte_en", bus.mem_byte_en, 0);
        check("async reset data words", {bus.fetch_data, bus.data_rdata}, 0);
        step();
        reset_n = 1'b1;
        step();
        run_vec(vt[1]);
        run_vec(vt[0]);

        repeat (3) step();
        check("issue queue drained", iq.size(), 0);
        check("fetch queue drained", fq.size(), 0);
        check("data queue drained", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
